// File: rtl/ring_meas_pkg.sv
// Shared types and defaults for the ring oscillator frequency meter.
// FSM encodings plus default window and counter sizes.
package ring_meas_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  localparam int unsigned DEF_GATE_CYCLES = 1024;
  localparam int unsigned DEF_CNT_W       = 16;

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser plus delay flop for an async pad input.
// Emits a one-cycle pulse on each synchronised rising edge.
module sync_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // metastability chain followed by the edge-compare delay flop
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/ring_freq_meter.sv
// Counts synchronised ring-oscillator edges over a gate window.
// Result is latched with a one-cycle valid strobe at window close.
module ring_freq_meter
  import ring_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] count_out,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0] T_LOAD = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;

  state_t state;
  state_t state_nx;

  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             sat;
  logic             sat_inc;
  logic             at_max;
  logic             rise;
  logic             launch;
  logic             closing;

  sync_rise_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (osc_in),
    .rise (rise)
  );

  // saturating edge count including this cycle's edge
  always_comb begin
    at_max  = (cnt == C_MAX);
    cnt_inc = cnt;
    if (rise && !at_max) begin
      cnt_inc = cnt + CNT_W'(1);
    end
    sat_inc = sat | (rise & at_max);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state and window control strobes
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    launch   = 1'b0;
    closing  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start | cont) begin
          launch   = 1'b1;
          state_nx = GATE;
        end
      end
      GATE: begin
        busy = 1'b1;
        if (timer == '0) begin
          closing = 1'b1;
          if (!cont) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // gate timer, edge counter and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (launch) begin
        timer <= T_LOAD;
        cnt   <= '0;
        sat   <= 1'b0;
      end else if (closing) begin
        count_out <= cnt_inc;
        overflow  <= sat_inc;
        valid     <= 1'b1;
        timer     <= T_LOAD;
        cnt       <= '0;
        sat       <= 1'b0;
      end else if (busy) begin
        timer <= timer - TW'(1);
        cnt   <= cnt_inc;
        sat   <= sat_inc;
      end
    end
  end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Directed bench for ring_freq_meter.
// Three instances cover exact count, saturation and continuous mode.
module tb_ring_freq_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic osc_in = 1'b0;
  int   osc_per = 10;
  int   ph = 0;
  int   edges = 0;

  logic        start_a = 1'b0;
  logic        cont_a = 1'b0;
  logic [15:0] count_a;
  logic        valid_a;
  logic        busy_a;
  logic        ovf_a;

  logic        start_s = 1'b0;
  logic        cont_s = 1'b0;
  logic [3:0]  count_s;
  logic        valid_s;
  logic        busy_s;
  logic        ovf_s;

  logic        start_c = 1'b0;
  logic        cont_c = 1'b0;
  logic [15:0] count_c;
  logic        valid_c;
  logic        busy_c;
  logic        ovf_c;

  int vectors = 0;
  int miscompares = 0;
  int nv;
  int nb;
  int sum;
  int e0;
  int e1;

  ring_freq_meter #(.GATE_CYCLES(100), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .osc_in(osc_in),
    .start(start_a), .cont(cont_a),
    .count_out(count_a), .valid(valid_a),
    .busy(busy_a), .overflow(ovf_a)
  );

  ring_freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) u_s (
    .clk(clk), .rst(rst), .osc_in(osc_in),
    .start(start_s), .cont(cont_s),
    .count_out(count_s), .valid(valid_s),
    .busy(busy_s), .overflow(ovf_s)
  );

  ring_freq_meter #(.GATE_CYCLES(64), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .osc_in(osc_in),
    .start(start_c), .cont(cont_c),
    .count_out(count_c), .valid(valid_c),
    .busy(busy_c), .overflow(ovf_c)
  );

  always #5 clk = ~clk;

  // oscillator: changes 7 ns after each posedge, period in clk cycles
  always begin
    @(posedge clk);
    #7;
    if (osc_per == 0) begin
      osc_in = 1'b0;
      ph = 0;
    end else begin
      osc_in = (ph < osc_per / 2);
      ph = (ph + 1 >= osc_per) ? 0 : ph + 1;
    end
  end

  // reference count of raw oscillator rising edges
  always @(posedge osc_in) edges = edges + 1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset with oscillator toggling
    repeat (3) begin
      @(negedge clk);
      check("rst_count", 32'(count_a), 0);
      check("rst_valid", 32'(valid_a), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_ovf", 32'(ovf_a), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_count", 32'(count_a), 0);
    check("post_rst_busy", 32'(busy_a), 0);
    check("post_rst_valid", 32'(valid_a), 0);

    // 2: exact count, period 10 over 100 cycles
    repeat (20) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("exact_busy_t1", 32'(busy_a), 1);
    nv = 0;
    nb = 0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (j < 100) begin
        if (valid_a) nv++;
        if (!busy_a) nb++;
      end else begin
        check("exact_valid", 32'(valid_a), 1);
        check("exact_count", 32'(count_a), 10);
        check("exact_ovf", 32'(ovf_a), 0);
        check("exact_busy_low", 32'(busy_a), 0);
      end
    end
    check("exact_early_valid", 32'(nv), 0);
    check("exact_busy_gap", 32'(nb), 0);
    @(negedge clk);
    check("exact_valid_1cyc", 32'(valid_a), 0);
    check("exact_hold", 32'(count_a), 10);

    // 6a: abort at window cycle 40
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_count", 32'(count_a), 0);
    check("abort_busy", 32'(busy_a), 0);
    check("abort_valid", 32'(valid_a), 0);
    check("abort_ovf", 32'(ovf_a), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_idle", 32'(busy_a), 0);

    // 6b: fresh window with an ignored start mid-window
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (j == 50) start_a = 1'b1;
      if (j == 51) start_a = 1'b0;
      if (j == 100) begin
        check("fresh_valid", 32'(valid_a), 1);
        check("fresh_count", 32'(count_a), 10);
      end
    end
    nv = 0;
    nb = 0;
    for (int j = 0; j < 150; j++) begin
      @(negedge clk);
      if (valid_a) nv++;
      if (busy_a) nb++;
    end
    check("ignored_start_valid", 32'(nv), 0);
    check("ignored_start_busy", 32'(nb), 0);

    // 3: static input
    osc_per = 0;
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    nv = 0;
    for (int j = 1; j <= 120; j++) begin
      @(negedge clk);
      if (valid_a) nv++;
      if (j == 100) begin
        check("static_valid", 32'(valid_a), 1);
        check("static_count", 32'(count_a), 0);
      end
    end
    check("static_one_pulse", 32'(nv), 1);

    // 4: saturation with a 4-bit counter
    osc_per = 4;
    repeat (10) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (j == 100) begin
        check("sat_valid", 32'(valid_s), 1);
        check("sat_count", 32'(count_s), 15);
        check("sat_ovf", 32'(ovf_s), 1);
      end
    end
    osc_per = 0;
    repeat (10) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (j == 50) begin
        check("sat_hold_count", 32'(count_s), 15);
        check("sat_hold_ovf", 32'(ovf_s), 1);
      end
      if (j == 100) begin
        check("unsat_valid", 32'(valid_s), 1);
        check("unsat_count", 32'(count_s), 0);
        check("unsat_ovf", 32'(ovf_s), 0);
      end
    end

    // 5: continuous mode, 5 windows of 64, period 6
    osc_per = 6;
    repeat (10) @(negedge clk);
    @(negedge clk);
    e0 = edges;
    e1 = 0;
    @(negedge clk);
    cont_c = 1'b1;
    @(negedge clk);
    check("cont_busy_t1", 32'(busy_c), 1);
    nv = 0;
    nb = 0;
    sum = 0;
    for (int k = 1; k <= 5; k++) begin
      for (int j = 1; j <= 64; j++) begin
        @(negedge clk);
        if (k == 5 && j == 62) e1 = edges;
        if (j < 64) begin
          if (valid_c) nv++;
          if (!busy_c) nb++;
        end else begin
          check($sformatf("cont_valid_w%0d", k), 32'(valid_c), 1);
          sum += int'(count_c);
          if (k < 5) begin
            check($sformatf("cont_busy_w%0d", k), 32'(busy_c), 1);
          end
          if (k == 4) cont_c = 1'b0;
        end
      end
    end
    check("cont_stray_valid", 32'(nv), 0);
    check("cont_busy_gap", 32'(nb), 0);
    check("cont_busy_end", 32'(busy_c), 0);
    check("cont_sum_edges", 32'(sum), 32'(e1 - e0));
    check("cont_sum_range", 32'(sum inside {53, 54}), 1);
    @(negedge clk);
    check("cont_valid_end", 32'(valid_c), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ring_freq_meter.md
Name: ring_freq_meter

Overview:
- Consumes the free-running ring-oscillator output (raw or pre-divided tap) and measures its frequency in the system clock domain.
- Synchronises the asynchronous oscillator signal and counts its rising edges over a programmable gate window of clk cycles.
- Presents the latched count with a one-cycle valid strobe.
- Sits directly downstream of the tapped ring oscillator; feeds the chip output mux or a readout shifter.

Parameters:
- GATE_CYCLES, 1024, gate window length in clk cycles (>= 2).
- CNT_W, 16, width of the edge counter and result.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- osc_in  input  1  asynchronous oscillator signal; high and low phases each > 1 clk period.
- start  input  1  request one measurement; sampled only in IDLE.
- cont  input  1  continuous mode; back-to-back windows while high.
- count_out  output  CNT_W  result of the last completed window.
- valid  output  1  one-cycle pulse when count_out updates.
- busy  output  1  high while a window is open.
- overflow  output  1  last completed window saturated.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: count_out=0, valid=0, busy=0, overflow=0. Internal state: FSM=IDLE, edge counter=0, gate timer=0, synchroniser flops=0.
- Synchroniser:
  - Path is 2-flop sync, then a delay flop; rise = s2 & ~s3.
  - osc_in rising edge to rise pulse latency is 2-3 clk cycles.
- FSM states: IDLE, GATE.
- IDLE:
  - If (start | cont) is high at cycle T: clear edge counter, load timer=GATE_CYCLES-1, go to GATE.
  - busy=1 from T+1.
- GATE:
  - Open for exactly GATE_CYCLES cycles, T+1 .. T+GATE_CYCLES.
  - Each cycle with rise=1 increments the counter.
  - Counter saturates at 2^CNT_W-1 and sets an internal sat flag; it never wraps.
  - Timer decrements each cycle.
- Window close (cycle where timer==0 in GATE):
  - A rise on this cycle counts in the closing window.
  - Next cycle: count_out=final count, overflow=sat, valid=1 for one cycle.
  - If cont=1 on the closing cycle: reload the timer, clear counter and sat, stay in GATE. No gap cycle: the next window starts the very next cycle, and valid coincides with that window's first cycle.
  - Else go to IDLE; busy=0.
- start while busy is ignored and not queued.
- cont dropping mid-window: the current window completes normally, then the FSM goes to IDLE.
- rst mid-window: abort immediately, return to reset values, discard the partial count.
- count_out and overflow hold until the next window completes.
- Width rules: timer width = clog2(GATE_CYCLES); all counter arithmetic is unsigned CNT_W.

Decomposition:
- Shared package ring_meas_pkg holds:
  - FSM state encodings: IDLE=1'b0, GATE=1'b1.
  - Default GATE_CYCLES and CNT_W constants.
- One sub-module: sync_rise_det. Contains the 2-flop synchroniser, delay flop and rising-edge pulse, with synchronous active-high rst. It is reusable for other async pad inputs.

Test Plan:
1. Reset values: assert rst 3 cycles with osc toggling -> count_out=0, valid=0, busy=0, overflow=0 throughout and after release.
2. Exact count: GATE_CYCLES=100, osc_in period 10 clk, rising edges phase-aligned mid-cycle, start one cycle -> valid at T+101, count_out=10, overflow=0, busy low at T+101.
3. Static input: osc_in held 0, start -> count_out=0, valid pulses once at T+GATE_CYCLES+1.
4. Saturation: CNT_W=4, GATE_CYCLES=100, osc period 4 clk -> count_out=15, overflow=1. Next window with osc static -> count_out=0, overflow=0.
5. Continuous mode: cont=1 for 5 windows, GATE_CYCLES=64, osc period 6 clk.
   - valid exactly every 64 cycles; busy stays 1.
   - Sum of the 5 counts equals the total synchronised edges (±0), so no edge is lost or double-counted at window boundaries.
6. Abort and ignore:
   - rst at mid-window cycle 40 -> outputs return to reset values.
   - Fresh start -> correct full count.
   - start pulsed during GATE -> no extra window and no extra valid.
